// File: rtl/div_rem_unit.sv
// Iterative restoring radix-2 divide/remainder unit (DIV, DIVU, REM, REMU), one quotient bit per cycle.
// Optional macro DIV_REM_EARLY_OUT_EN: divide-by-zero, signed overflow and |DATA2|>|DATA1| skip the iterations.
module div_rem_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [1:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  state_e           state_q;
  logic             rem_op_q;
  logic             sgn_a_q, sgn_b_q;
  logic             dz_q, ovf_q, early_q;
  logic [XLEN-1:0]  a_raw_q;
  logic [XLEN-1:0]  quot_q, rem_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;
  logic [XLEN-1:0]  res_q;

  // Operand preparation at acceptance
  logic            is_signed, a_neg, b_neg, dz, ovf;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    is_signed = ~SELECT[0];
    a_neg     = is_signed & DATA1[XLEN-1];
    b_neg     = is_signed & DATA2[XLEN-1];
    a_mag     = a_neg ? (~DATA1 + 1'b1) : DATA1;
    b_mag     = b_neg ? (~DATA2 + 1'b1) : DATA2;
    dz        = (DATA2 == '0);
    ovf       = is_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
  end

  // One restoring step; rem_q < divisor keeps the 33-bit difference sign-correct
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_d, quot_d;

  always_comb begin
    shifted = {rem_q, quot_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[XLEN]) begin
      rem_d  = diff[XLEN-1:0];
      quot_d = {quot_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d  = shifted[XLEN-1:0];
      quot_d = {quot_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign correction plus the architecturally mandated special cases
  logic [XLEN-1:0] q_fix, r_fix, fin_res;

  always_comb begin
    q_fix = (sgn_a_q ^ sgn_b_q) ? (~quot_q + 1'b1) : quot_q;
    r_fix = sgn_a_q ? (~rem_q + 1'b1) : rem_q;
    if (dz_q)
      fin_res = rem_op_q ? a_raw_q : '1;
    else if (ovf_q)
      fin_res = rem_op_q ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else
      fin_res = rem_op_q ? r_fix : q_fix;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      rem_op_q <= 1'b0;
      sgn_a_q  <= 1'b0;
      sgn_b_q  <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      early_q  <= 1'b0;
      a_raw_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START && !FLUSH) begin
            rem_op_q <= SELECT[1];
            sgn_a_q  <= a_neg;
            sgn_b_q  <= b_neg;
            dz_q     <= dz;
            ovf_q    <= ovf;
            a_raw_q  <= DATA1;
            quot_q   <= a_mag;
            rem_q    <= '0;
            dvs_q    <= b_mag;
            cnt_q    <= CNT_W'(XLEN);
            early_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_CALC;
`ifdef DIV_REM_EARLY_OUT_EN
            // A single non-iterating CALC cycle lands DONE two cycles after START
            if (dz || ovf || (b_mag > a_mag)) begin
              early_q <= 1'b1;
              cnt_q   <= CNT_W'(1);
              quot_q  <= '0;
              rem_q   <= a_mag;
            end
`endif
          end
        end
        S_CALC: begin
          if (FLUSH) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (!early_q) begin
              rem_q  <= rem_d;
              quot_q <= quot_d;
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!FLUSH) begin
            res_q  <= fin_res;
            done_q <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = res_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed table-driven bench for div_rem_unit plus back-to-back, flush and async-reset sequences.
module tb_div_rem_unit;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        FLUSH = 1'b0;
  logic [1:0]  SELECT = 2'b00;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        BUSY, DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  always #5 CLK = ~CLK;

  div_rem_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .FLUSH(FLUSH), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[20];

  function automatic int exp_lat(input bit early);
`ifdef DIV_REM_EARLY_OUT_EN
    return early ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Caller is #1 after a posedge; START is accepted on the next edge, then operands are scrambled
  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    SELECT = s; DATA1 = a; DATA2 = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    DATA1 = $urandom; DATA2 = $urandom; SELECT = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done(output int lat, output logic [31:0] res);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    res  = 'x;
    for (int k = 1; k <= 100; k++) begin
      if (!seen) begin
        @(posedge CLK); #1;
        if (DONE) begin
          seen = 1'b1;
          lat  = k;
          res  = RESULT;
        end
      end
    end
  endtask

  task automatic count_done(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge CLK); #1;
      if (DONE) seen++;
    end
  endtask

  initial begin
    int          lat, n;
    logic [31:0] res;

    vecs[0]  = '{OP_DIV,  32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFA, 1'b0};
    vecs[1]  = '{OP_REM,  32'hFFFFFFEC, 32'h00000003, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{OP_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 1'b0};
    vecs[3]  = '{OP_REMU, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 1'b0};
    vecs[4]  = '{OP_DIV,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b1};
    vecs[5]  = '{OP_REM,  32'h00000007, 32'h00000000, 32'h00000007, 1'b1};
    vecs[6]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[7]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[8]  = '{OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 1'b0};
    vecs[9]  = '{OP_REMU, 32'd100,      32'd7,        32'h00000002, 1'b0};
    vecs[10] = '{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    vecs[13] = '{OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[14] = '{OP_DIVU, 32'h00000003, 32'h00000005, 32'h00000000, 1'b1};
    vecs[15] = '{OP_REMU, 32'h00000003, 32'h00000005, 32'h00000003, 1'b1};
    vecs[16] = '{OP_DIV,  32'h80000000, 32'h00000002, 32'hC0000000, 1'b0};
    vecs[17] = '{OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[18] = '{OP_REM,  32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 1'b1};
    vecs[19] = '{OP_DIVU, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 1'b1};

    #2;
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_result", RESULT, 32'h0);
    #20 RESET_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].sel, vecs[i].a, vecs[i].b);
      wait_done(lat, res);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].early)));
      chk($sformatf("v%0d_busy_at_done", i), 32'(BUSY), 32'd0);
    end

    // Back-to-back: second START issued in the DONE cycle
    issue(OP_DIVU, 32'hFFFFFFFF, 32'h00000010);
    wait_done(lat, res);
    chk("b2b_first_result", res, 32'h0FFFFFFF);
    issue(OP_REMU, 32'hFFFFFFFF, 32'h00000010);
    chk("b2b_done_drop", 32'(DONE), 32'd0);
    chk("b2b_busy", 32'(BUSY), 32'd1);
    wait_done(lat, res);
    chk("b2b_second_result", res, 32'h0000000F);
    chk("b2b_second_latency", 32'(lat), 32'd33);

    // Ignored START while busy, then FLUSH mid-operation
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) begin @(posedge CLK); #1; end
    SELECT = OP_DIVU; DATA1 = 32'd1; DATA2 = 32'd1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy_after_ignored_start", 32'(BUSY), 32'd1);
    repeat (4) begin @(posedge CLK); #1; end
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    chk("flush_busy", 32'(BUSY), 32'd0);
    chk("flush_done", 32'(DONE), 32'd0);
    chk("flush_result_held", RESULT, 32'h0000000F);
    count_done(40, n);
    chk("flush_no_done", 32'(n), 32'd0);
    chk("flush_result_still_held", RESULT, 32'h0000000F);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, res);
    chk("post_flush_result", res, 32'h0000000E);
    chk("post_flush_latency", 32'(lat), 32'd33);

    // Asynchronous reset in the middle of an operation
    issue(OP_DIV, 32'hFFFFFFEC, 32'h00000003);
    repeat (14) begin @(posedge CLK); #1; end
    #2 RESET_N = 1'b0;
    #1;
    chk("areset_busy", 32'(BUSY), 32'd0);
    chk("areset_done", 32'(DONE), 32'd0);
    chk("areset_result", RESULT, 32'h0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    count_done(40, n);
    chk("areset_no_done", 32'(n), 32'd0);
    chk("areset_result_after", RESULT, 32'h0);
    issue(OP_REM, 32'hFFFFFFEC, 32'h00000003);
    wait_done(lat, res);
    chk("post_reset_result", res, 32'hFFFFFFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
